arith_8_responder: RTL and testbench

- Sequential responder for 8-bit arithmetic requests: the slave end of the request/result exchange that the arithmetic unit bench drives.
- Accepts (A, B, AluOp) on a valid/ready request channel, computes in a single stage, and queues results in a small FIFO.
- Returns result, carry and illegal-op status on a valid/ready response channel; keeps a completed-operation counter.
- Sits between a controller/sequencer and the datapath so issue rate is decoupled from consumption.

---
 rtl/arith_8_pkg.sv | 67 ++++++
 rtl/arith_8_responder_if.sv | 26 ++
 rtl/arith_8_rsp_fifo.sv | 50 +++++
 rtl/arith_8_responder.sv | 83 ++++++++
 tb/tb_arith_8_responder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arith_8_pkg.sv
// rtl/arith_8_pkg.sv - op codes, result struct and single-stage op evaluator
// Defining ARITH8_ACCUM_EN makes OP_ACC_ADD / OP_ACC_CLR legal.
package arith_8_pkg;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_RSUB    = 3'b001;
  localparam logic [2:0] OP_INC     = 3'b010;
  localparam logic [2:0] OP_ACC_ADD = 3'b011;
  localparam logic [2:0] OP_ACC_CLR = 3'b100;
  localparam logic [2:0] OP_EQ      = 3'b101;
  localparam logic [2:0] OP_SHL     = 3'b110;
  localparam logic [2:0] OP_SHR     = 3'b111;

  typedef struct packed {
    logic       illegal;
    logic       cout;
    logic [7:0] result;
  } arith_8_res_t;

  function automatic arith_8_res_t arith_8_eval(input logic [2:0] op,
                                                input logic [7:0] a,
                                                input logic [7:0] b,
                                                input logic [7:0] acc);
    arith_8_res_t r;
    logic [8:0]   s;
    r = '0;
    s = '0;
    case (op)
      OP_ADD: begin
        s        = {1'b0, a} + {1'b0, b};
        r.result = s[7:0];
        r.cout   = s[8];
      end
      OP_RSUB: begin
        // bit 8 of the 9-bit difference is the borrow; cout reports its absence
        s        = {1'b0, b} - {1'b0, a};
        r.result = s[7:0];
        r.cout   = ~s[8];
      end
      OP_INC: begin
        s        = {1'b0, a} + 9'd1;
        r.result = s[7:0];
        r.cout   = s[8];
      end
      OP_EQ:  r.result = {7'd0, (a == b)};
      OP_SHL: begin
        r.result = {a[6:0], 1'b0};
        r.cout   = a[7];
      end
      OP_SHR: begin
        r.result = {1'b0, a[7:1]};
        r.cout   = a[0];
      end
`ifdef ARITH8_ACCUM_EN
      OP_ACC_ADD: begin
        s        = {1'b0, acc} + {1'b0, a};
        r.result = s[7:0];
        r.cout   = s[8];
      end
      OP_ACC_CLR: r.result = acc;
`endif
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arith_8_responder_if.sv
// rtl/arith_8_responder_if.sv - request/response channels plus completed-op counter
interface arith_8_responder_if #(parameter int CNT_W = 16);

  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_a;
  logic [7:0]       req_b;
  logic [2:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic             rsp_cout;
  logic             rsp_illegal;
  logic [CNT_W-1:0] op_count;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_illegal, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_illegal, op_count
  );

endinterface

// File: rtl/arith_8_rsp_fifo.sv
// rtl/arith_8_rsp_fifo.sv - DEPTH x 10-bit synchronous FIFO with occupancy count
module arith_8_rsp_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [9:0]                 wdata_i,
  input  logic                       pop_i,
  output logic [9:0]                 rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;

  // Storage needs no reset: the count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({push_i, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/arith_8_responder.sv
// rtl/arith_8_responder.sv - valid/ready arithmetic responder with response FIFO
// Optional accumulator ops enabled by defining ARITH8_ACCUM_EN.
module arith_8_responder
  import arith_8_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  arith_8_responder_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  arith_8_res_t     res;
  arith_8_res_t     head;
  logic [CW-1:0]    count;
  logic             empty;
  logic             push;
  logic             pop;
  logic [7:0]       acc;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Ready depends on occupancy only, never on rsp_ready.
  assign bus.req_ready = (count < DEPTH_C);
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  assign res = arith_8_eval(bus.req_op, bus.req_a, bus.req_b, acc);

  arith_8_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (res),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count),
    .empty_o (empty)
  );

  assign bus.rsp_valid   = !empty;
  assign bus.rsp_result  = empty ? 8'd0 : head.result;
  assign bus.rsp_cout    = empty ? 1'b0 : head.cout;
  assign bus.rsp_illegal = empty ? 1'b0 : head.illegal;

`ifdef ARITH8_ACCUM_EN
  logic [7:0] acc_q;
  logic [7:0] acc_d;

  // ACC moves at push time so chained ACC_ADDs work while responses stall.
  always_comb begin
    acc_d = acc_q;
    if (push && bus.req_op == OP_ACC_ADD) acc_d = res.result;
    if (push && bus.req_op == OP_ACC_CLR) acc_d = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= 8'd0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;
`else
  assign acc = 8'd0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (pop && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.op_count = cnt_q;

endmodule

// File: tb/tb_arith_8_responder.sv
// tb/tb_arith_8_responder.sv - scoreboard bench for arith_8_responder
module tb_arith_8_responder;

  logic clk;
  logic rst_n;

  arith_8_responder_if #(.CNT_W(16)) bus ();

  arith_8_responder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         pop_cnt = 0;
  int         m_acc = 0;
  logic [9:0] exp_q[$];
  bit         stall_issued;
  bit         rand_done;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: {illegal, cout, result} from the op rules in plain integers.
  function automatic logic [9:0] model(input int a, input int b, input int op);
    int r;
    bit c;
    bit ill;
    r = 0; c = 0; ill = 0;
    case (op)
      0: begin r = a + b; c = (r > 255); end
      1: begin r = b - a; c = (b >= a); if (r < 0) r += 256; end
      2: begin r = a + 1; c = (a == 255); end
      5: r = (a == b) ? 1 : 0;
      6: begin r = a * 2; c = (a >= 128); end
      7: begin r = a / 2; c = (a % 2 == 1); end
`ifdef ARITH8_ACCUM_EN
      3: begin r = m_acc + a; c = (r > 255); m_acc = r % 256; end
      4: begin r = m_acc; m_acc = 0; end
`else
      default: ill = 1;
`endif
    endcase
    return {ill, c, 8'(r % 256)};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic issue(input int a, input int b, input int op);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_a     = 8'(a);
    bus.req_b     = 8'(b);
    bus.req_op    = 3'(op);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: got req_ready=0 expected 1 within 200 cycles");
    end else begin
      exp_q.push_back(model(a, b, op));
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // rsp_ready only changes just after a posedge so the monitor sees a stable value.
  task automatic set_ready(input logic v);
    @(posedge clk);
    #1;
    bus.rsp_ready = v;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic monitor();
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got result=%0h with no response expected", bus.rsp_result);
        end else begin
          e = exp_q.pop_front();
          pop_cnt++;
          check("rsp_entry", {bus.rsp_illegal, bus.rsp_cout, bus.rsp_result}, e);
        end
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    stall_issued  = 1'b0;
    rand_done     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_cout", bus.rsp_cout, 0);
    check("rst_rsp_illegal", bus.rsp_illegal, 0);
    check("rst_op_count", bus.op_count, 0);
    check("rst_req_ready", bus.req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    fork monitor(); join_none

    // Single add with one-cycle latency
    set_ready(1'b1);
    issue(15, 10, 0);
    check("latency_rsp_valid", bus.rsp_valid, 1);
    @(negedge clk);
    check("op_count_after_first", bus.op_count, 1);
    check("idle_rsp_valid", bus.rsp_valid, 0);

    // Back-to-back add / reverse subtract
    issue(200, 100, 0);
    issue(10, 25, 1);
    issue(30, 10, 1);
    drain();

    // Fill the FIFO with the consumer stalled
    set_ready(1'b0);
    issue(255, 0, 2);
    issue(1, 2, 0);
    check("full_req_ready", bus.req_ready, 0);
    fork
      begin
        issue(3, 4, 0);
        stall_issued = 1'b1;
      end
    join_none
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", bus.rsp_valid, 1);
      check("stall_rsp_result", bus.rsp_result, 0);
      check("stall_rsp_cout", bus.rsp_cout, 1);
      check("stall_req_ready", bus.req_ready, 0);
    end
    set_ready(1'b1);
    for (int i = 0; i < 20 && !stall_issued; i++) @(negedge clk);
    check("stall_third_accepted", stall_issued, 1);
    drain();

    // Compare and shifts
    issue(42, 42, 5);
    issue(42, 43, 5);
    issue(8'h81, 0, 6);
    issue(8'h0F, 0, 7);
    drain();

    // Accumulator ops (or illegal ops when the feature is absent)
    issue(100, 0, 3);
    issue(100, 0, 3);
    issue(100, 0, 3);
    issue(0, 0, 4);
    issue(5, 0, 3);
    issue(7, 9, 4);
    drain();

    // Randomized traffic with a randomly stalling consumer
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.rsp_ready = rand_done ? 1'b1 : 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 120; i++) begin
      issue($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_done = 1'b1;
    repeat (3) @(negedge clk);
    drain();
    check("op_count_total", bus.op_count, pop_cnt);

    // Asynchronous reset with two entries queued
    set_ready(1'b0);
    issue(1, 1, 0);
    issue(2, 2, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_rsp_result", bus.rsp_result, 0);
    check("midrst_op_count", bus.op_count, 0);
    check("midrst_req_ready", bus.req_ready, 1);
    exp_q.delete();
    m_acc   = 0;
    pop_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    issue(9, 9, 5);
    drain();
    check("postrst_pops", pop_cnt, 1);
    check("postrst_op_count", bus.op_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
